// File: rtl/intan_spi_master.sv
// SPI master for Intan headstage chips: 16-bit command out on copi, two
// 16-bit response words captured from cipo0/cipo1 with a programmable
// per-frame sampling delay to absorb the LVDS/cable round trip.
module intan_spi_master #(
   parameter int CLK_DIV         = 2,
   parameter int CSN_HIGH_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  sample_delay,
   output logic [15:0] rsp_data0,
   output logic [15:0] rsp_data1,
   output logic        rsp_valid,
   output logic        busy,
   output logic        sclk,
   output logic        csn,
   output logic        copi,
   input  logic        cipo0,
   input  logic        cipo1
);

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
   localparam logic [7:0] CS_M1  = 8'(CSN_HIGH_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DRAIN, CSHIGH} state_t;

   state_t      state;
   logic [7:0]  div_cnt;    // clk count within the current SCLK half-period
   logic [4:0]  fall_cnt;   // SCLK falls completed this frame
   logic [14:0] tx_sr;      // command bits still to be presented on copi
   logic [3:0]  dly;        // sample_delay latched at acceptance
   logic [15:0] strb_pipe;  // strb_pipe[k] = SCLK rose k cycles ago
   logic [4:0]  smp_cnt;    // saturates at 16
   logic [15:0] rx0, rx1;

   logic        accept, rise_evt, strobe, smp_done, fin;
   logic [15:0] rx0_nxt, rx1_nxt;
   logic [4:0]  smp_nxt;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = (state == IDLE) && cmd_valid;

   // Strobe/capture decode and the frame-complete condition.
   always_comb begin
      rise_evt = ((state == SETUP) && (div_cnt == DIV_M1)) ||
                 ((state == SHIFT) && (div_cnt == DIV_M1) && !sclk && (fall_cnt != 5'd16));
      strobe   = strb_pipe[dly] && (smp_cnt != 5'd16) && ((state == SHIFT) || (state == DRAIN));
      rx0_nxt  = strobe ? {rx0[14:0], cipo0} : rx0;
      rx1_nxt  = strobe ? {rx1[14:0], cipo1} : rx1;
      smp_nxt  = strobe ? smp_cnt + 5'd1 : smp_cnt;
      smp_done = (smp_nxt == 5'd16);
      // Close the frame once all SCLK periods are out and all 16 samples are in,
      // whichever finishes last.
      fin      = smp_done && ((state == DRAIN) ||
                 ((state == SHIFT) && (div_cnt == DIV_M1) && !sclk && (fall_cnt == 5'd16)));
   end

   // Strobe delay line: one bit per SCLK rise, cleared at reset and on each new frame.
   always_ff @(posedge clk) begin
      if (!rstn || accept) strb_pipe <= '0;
      else                 strb_pipe <= {strb_pipe[14:0], rise_evt};
   end

   // Frame sequencer with registered SPI outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         csn       <= 1'b1;
         sclk      <= 1'b0;
         copi      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data0 <= '0;
         rsp_data1 <= '0;
         div_cnt   <= '0;
         fall_cnt  <= '0;
         tx_sr     <= '0;
         dly       <= '0;
         smp_cnt   <= '0;
         rx0       <= '0;
         rx1       <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rx0       <= rx0_nxt;
         rx1       <= rx1_nxt;
         smp_cnt   <= smp_nxt;
         case (state)
            IDLE: if (cmd_valid) begin
               tx_sr    <= cmd_data[14:0];
               copi     <= cmd_data[15];
               csn      <= 1'b0;
               dly      <= sample_delay;
               div_cnt  <= '0;
               fall_cnt <= '0;
               smp_cnt  <= '0;
               rx0      <= '0;
               rx1      <= '0;
               state    <= SETUP;
            end
            SETUP: if (div_cnt == DIV_M1) begin
               div_cnt <= '0;
               sclk    <= 1'b1;
               state   <= SHIFT;
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
            SHIFT: if (div_cnt == DIV_M1) begin
               div_cnt <= '0;
               if (sclk) begin
                  sclk     <= 1'b0;
                  fall_cnt <= fall_cnt + 5'd1;
                  // copi keeps bit 0 after the last fall.
                  if (fall_cnt != 5'd15) begin
                     copi  <= tx_sr[14];
                     tx_sr <= {tx_sr[13:0], 1'b0};
                  end
               end else if (fall_cnt == 5'd16) begin
                  state <= DRAIN;
               end else begin
                  sclk <= 1'b1;
               end
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
            DRAIN: ;
            CSHIGH: if (div_cnt == CS_M1) state <= IDLE;
                    else div_cnt <= div_cnt + 8'd1;
            default: state <= IDLE;
         endcase
         // The csn-high cycle counts toward the inter-frame gap.
         if (fin) begin
            csn       <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data0 <= rx0_nxt;
            rsp_data1 <= rx1_nxt;
            div_cnt   <= 8'd1;
            state     <= (CSN_HIGH_CYCLES == 1) ? IDLE : CSHIGH;
         end
      end
   end

endmodule

// File: tb/tb_intan_spi_master.sv
// Randomised bench for intan_spi_master with a frame-timeline reference model.
module tb_intan_spi_master;

   localparam int D = 2;
   localparam int H = 8;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] cmd_data = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  sample_delay = '0;
   logic [15:0] rsp_data0, rsp_data1;
   logic        rsp_valid, busy, sclk, csn, copi;
   logic        cipo0, cipo1;
   logic        c0_r = 1'b0, c1_r = 1'b0;
   int          mode = 0;            // 0 loopback, 1 random, 2 chip word
   logic [15:0] chip_word = '0;

   assign cipo0 = (mode == 0) ? copi  : c0_r;
   assign cipo1 = (mode == 0) ? ~copi : c1_r;

   intan_spi_master #(.CLK_DIV(D), .CSN_HIGH_CYCLES(H)) dut (
      .clk(clk), .rstn(rstn), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .sample_delay(sample_delay),
      .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .rsp_valid(rsp_valid),
      .busy(busy), .sclk(sclk), .csn(csn), .copi(copi),
      .cipo0(cipo0), .cipo1(cipo1));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   // model state
   bit          started = 0, in_frame = 0;
   int          fc = 0, m_T = 0, m_dly = 0;
   logic [15:0] m_cmd = '0, e_rsp0 = '0, e_rsp1 = '0;
   logic        e_copi_idle = 1'b0;
   logic        h0 [0:255];
   logic        h1 [0:255];

   // observations for the literal checks
   logic [15:0] obs_copi = '0;
   int          rise_cnt = 0, csn_rise = 0, run = 0, last_run = 0, vld_cnt = 0;
   logic        prev_sclk = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference timeline + per-cycle compare
   initial begin
      bit rs, acc;
      logic [15:0] cd;
      int sd;
      forever begin
         @(posedge clk);
         rs  = rstn;
         acc = rstn && cmd_valid && started && !in_frame;
         cd  = cmd_data;
         sd  = int'(sample_delay);
         if (in_frame) begin h0[fc] = cipo0; h1[fc] = cipo1; end
         #1;
         if (!rs) begin
            started = 1; in_frame = 0; fc = 0;
            e_rsp0 = '0; e_rsp1 = '0; e_copi_idle = 1'b0;
         end else if (acc) begin
            in_frame = 1; fc = 1; m_cmd = cd; m_dly = sd;
            m_T = (1 + 33*D > 2 + 31*D + sd) ? 1 + 33*D : 2 + 31*D + sd;
            obs_copi = '0; rise_cnt = 0; csn_rise = 0;
         end else if (in_frame) begin
            fc++;
            if (fc == m_T + H - 1) begin in_frame = 0; e_copi_idle = m_cmd[0]; end
         end
         if (started) begin
            logic e_csn, e_sclk, e_copi, e_vld, e_busy;
            int f;
            if (in_frame) begin
               e_csn  = (fc >= m_T);
               e_sclk = (fc >= 1 + D) && (fc <= 33*D) && (((fc - 1 - D) / D) % 2 == 0);
               f = (fc >= 1 + 2*D) ? (fc - 1 - 2*D) / (2*D) + 1 : 0;
               if (f > 15) f = 15;
               e_copi = m_cmd[15 - f];
               e_vld  = (fc == m_T);
               e_busy = 1'b1;
               if (fc == m_T)
                  for (int i = 0; i < 16; i++) begin
                     e_rsp0[15 - i] = h0[1 + D + 2*D*i + m_dly];
                     e_rsp1[15 - i] = h1[1 + D + 2*D*i + m_dly];
                  end
            end else begin
               e_csn = 1'b1; e_sclk = 1'b0; e_copi = e_copi_idle; e_vld = 1'b0; e_busy = 1'b0;
            end
            chk("csn", csn, e_csn);
            chk("sclk", sclk, e_sclk);
            chk("copi", copi, e_copi);
            chk("rsp_valid", rsp_valid, e_vld);
            chk("busy", busy, e_busy);
            chk("cmd_ready", cmd_ready, !e_busy);
            chk("rsp_data0", rsp_data0, e_rsp0);
            chk("rsp_data1", rsp_data1, e_rsp1);
            if (in_frame) begin
               if (sclk && !prev_sclk) begin rise_cnt++; obs_copi = {obs_copi[14:0], copi}; end
               if (csn && csn_rise == 0) csn_rise = fc;
            end
            prev_sclk = sclk;
            if (csn) run++;
            else begin if (run > 0) last_run = run; run = 0; end
            if (rsp_valid) vld_cnt++;
         end
      end
   end

   // CIPO driver: random data, or a chip replying bit i m_dly cycles after rise i
   initial begin
      int i;
      forever begin
         @(negedge clk);
         c0_r = 1'($urandom);
         c1_r = 1'($urandom);
         if (mode == 2 && in_frame && fc >= 1 + D + m_dly) begin
            i = (fc - 1 - D - m_dly) / (2*D);
            if (i > 15) i = 15;
            c0_r = chip_word[15 - i];
         end
      end
   end

   task automatic timeout(input string nm);
      n_chk++;
      $display("FAIL timeout %s: waited 400 cycles, required event did not occur", nm);
   endtask

   task automatic wait_done(input bit poke);
      int k = 0;
      while (in_frame && k < 400) begin
         @(negedge clk);
         if (poke) cmd_valid = (in_frame && fc < m_T) ? 1'($urandom) : 1'b0;
         k++;
      end
      if (k >= 400) timeout("frame end");
   endtask

   task automatic send(input logic [15:0] c, input int dl, input int md, input bit hold);
      wait_done(0);
      mode = md; cmd_data = c; sample_delay = 4'(dl); cmd_valid = 1'b1;
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_fc(input int n);
      int k = 0;
      while (!(in_frame && fc >= n) && k < 400) begin @(negedge clk); k++; end
      if (k >= 400) timeout("frame cycle");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // loopback, delay 0
      send(16'hE800, 0, 0, 0); wait_done(0);
      chk("lit copi bits", obs_copi, 16'hE800);
      chk("lit sclk pulses", rise_cnt, 16);
      chk("lit csn rise e800", csn_rise, 67);
      chk("lit rsp0 e800", rsp_data0, 16'hE800);
      chk("lit rsp1 e800", rsp_data1, 16'h17FF);

      // delayed chip reply
      chip_word = 16'hA5C3;
      send(16'h0000, 7, 2, 0); wait_done(0);
      chk("lit rsp0 a5c3", rsp_data0, 16'hA5C3);
      chk("lit csn rise d7", csn_rise, 71);

      // back-to-back with cmd_valid held
      v0 = vld_cnt;
      send(16'h1234, 3, 1, 1); wait_done(0);
      wait_fc(1); wait_done(0);
      cmd_valid = 1'b0;
      chk("lit csn gap", last_run, H);
      chk("lit b2b frames", vld_cnt - v0, 2);

      // reset mid-frame
      v0 = vld_cnt;
      send(16'hBEEF, 5, 1, 0);
      wait_fc(20);
      rstn = 1'b0;
      @(negedge clk);
      chk("lit reset no rsp", vld_cnt - v0, 0);
      rstn = 1'b1;
      @(negedge clk);
      send(16'h5A5A, 1, 0, 0); wait_done(0);
      chk("lit rsp0 after reset", rsp_data0, 16'h5A5A);

      // sample_delay change mid-frame
      send(16'hC3C3, 0, 0, 0);
      wait_fc(10);
      sample_delay = 4'd15;
      wait_done(0);
      chk("lit csn rise dly ignored", csn_rise, 67);
      chk("lit rsp0 c3c3", rsp_data0, 16'hC3C3);
      chip_word = 16'h3C3C;
      send(16'h8001, 15, 2, 0); wait_done(0);
      chk("lit csn rise d15", csn_rise, 79);
      chk("lit rsp0 3c3c", rsp_data0, 16'h3C3C);

      // randomised frames
      for (int n = 0; n < 16; n++) begin
         chip_word = 16'($urandom);
         send(16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 0);
         wait_done(1);
      end
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
